// File: rtl/float_argmax_stream_pkg.sv
// Shared definitions for the float arg-max stream: default field widths,
// state encodings and sign/magnitude slice helpers.
`ifndef FLOAT_ARGMAX_STREAM_PKG_SV
`define FLOAT_ARGMAX_STREAM_PKG_SV

// Sign bit and magnitude bits of a D-bit {sign, exp, frac} word
`define FLOAT_SIGN(w, d) w[(d)-1]
`define FLOAT_MAG(w, d)  w[(d)-2:0]

package float_argmax_stream_pkg;

  localparam int E_BIT_DEF = 5;
  localparam int F_BIT_DEF = 10;
  localparam int D_LEN_DEF = E_BIT_DEF + F_BIT_DEF + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`endif

// File: rtl/float_argmax_stream_gt_cmp.sv
// float_gt_cmp: combinational sign/magnitude compare of two floats, giving
// strict a>b and a==b (with +0 and -0 treated as equal). No NaN/Inf handling.
module float_gt_cmp #(
  parameter int E_BIT = 5,
  parameter int F_BIT = 10,
  localparam int D_LEN = E_BIT + F_BIT + 1
) (
  input  logic [D_LEN-1:0] a,
  input  logic [D_LEN-1:0] b,
  output logic             gt,
  output logic             eq
);

  logic             sign_a_s;
  logic             sign_b_s;
  logic [D_LEN-2:0] mag_a_s;
  logic [D_LEN-2:0] mag_b_s;
  logic             both_zero_s;

  assign sign_a_s    = `FLOAT_SIGN(a, D_LEN);
  assign sign_b_s    = `FLOAT_SIGN(b, D_LEN);
  assign mag_a_s     = `FLOAT_MAG(a, D_LEN);
  assign mag_b_s     = `FLOAT_MAG(b, D_LEN);
  assign both_zero_s = (mag_a_s == {(D_LEN-1){1'b0}}) && (mag_b_s == {(D_LEN-1){1'b0}});
  assign eq          = (a == b) || both_zero_s;

  // Negative values order inversely to their magnitude
  always_comb begin
    gt = 1'b0;
    if (sign_a_s != sign_b_s) begin
      gt = !sign_a_s && !both_zero_s;
    end else if (!sign_a_s) begin
      gt = (mag_a_s > mag_b_s);
    end else begin
      gt = (mag_a_s < mag_b_s);
    end
  end

endmodule

// File: rtl/float_argmax_stream.sv
// Streaming arg-max over N_IN floats with valid/ready in and out handshakes.
// Define FLOAT_ARGMAX_TIE_LAST_EN to keep the last of equal maxima instead of the first.
module float_argmax_stream
  import float_argmax_stream_pkg::*;
#(
  parameter int E_BIT = E_BIT_DEF,
  parameter int F_BIT = F_BIT_DEF,
  parameter int D_LEN = E_BIT + F_BIT + 1,
  parameter int N_IN  = 10,
  parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_LEN-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_LEN-1:0] out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  logic [1:0]       state_r, state_nxt_s;
  logic [IDX_W-1:0] cnt_r, cnt_nxt_s;
  logic [D_LEN-1:0] best_r, best_nxt_s;
  logic [IDX_W-1:0] best_idx_r, best_idx_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic [D_LEN-1:0] out_val_r, out_val_nxt_s;
  logic [IDX_W-1:0] out_idx_r, out_idx_nxt_s;
  logic             in_ready_r;
  logic             busy_r;
  logic             gt_s;
  logic             eq_s;
  logic             upd_s;

  float_gt_cmp #(
    .E_BIT (E_BIT),
    .F_BIT (F_BIT)
  ) u_cmp (
    .a  (in_data),
    .b  (best_r),
    .gt (gt_s),
    .eq (eq_s)
  );

`ifdef FLOAT_ARGMAX_TIE_LAST_EN
  assign upd_s = gt_s || eq_s;
`else
  assign upd_s = gt_s;
`endif

  // Next-state, running max and result capture; clr overrides any transfer
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    best_nxt_s      = best_r;
    best_idx_nxt_s  = best_idx_r;
    out_valid_nxt_s = out_valid_r;
    out_val_nxt_s   = out_val_r;
    out_idx_nxt_s   = out_idx_r;
    if (clr) begin
      state_nxt_s     = ST_IDLE;
      cnt_nxt_s       = {IDX_W{1'b0}};
      out_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            best_nxt_s     = in_data;
            best_idx_nxt_s = {IDX_W{1'b0}};
            if (N_IN == 1) begin
              cnt_nxt_s       = {IDX_W{1'b0}};
              state_nxt_s     = ST_DONE;
              out_valid_nxt_s = 1'b1;
              out_val_nxt_s   = in_data;
              out_idx_nxt_s   = {IDX_W{1'b0}};
            end else begin
              cnt_nxt_s   = IDX_W'(1);
              state_nxt_s = ST_ACC;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            if (upd_s) begin
              best_nxt_s     = in_data;
              best_idx_nxt_s = cnt_r;
            end else begin
              best_nxt_s     = best_r;
            end
            // The result is taken from the updated best, not the stale register
            if (cnt_r == LAST_IDX) begin
              state_nxt_s     = ST_DONE;
              out_valid_nxt_s = 1'b1;
              out_val_nxt_s   = upd_s ? in_data : best_r;
              out_idx_nxt_s   = upd_s ? cnt_r : best_idx_r;
            end else begin
              cnt_nxt_s = cnt_r + IDX_W'(1);
            end
          end else begin
            state_nxt_s = ST_ACC;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_nxt_s = 1'b0;
            cnt_nxt_s       = {IDX_W{1'b0}};
            state_nxt_s     = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          cnt_nxt_s       = {IDX_W{1'b0}};
          out_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, accumulator and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {IDX_W{1'b0}};
      best_r      <= {D_LEN{1'b0}};
      best_idx_r  <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      out_val_r   <= {D_LEN{1'b0}};
      out_idx_r   <= {IDX_W{1'b0}};
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      best_r      <= best_nxt_s;
      best_idx_r  <= best_idx_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_val_r   <= out_val_nxt_s;
      out_idx_r   <= out_idx_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_val   = out_val_r;
  assign out_idx   = out_idx_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_float_argmax_stream.sv
// Self-checking bench for float_argmax_stream: table-driven reductions with a
// result scoreboard, plus backpressure, clr, async reset and N_IN=1 sequences.
module tb_float_argmax_stream;

`ifdef FLOAT_ARGMAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data, out_val;
  logic [1:0]  out_idx;
  logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
  logic [15:0] in_data_1, out_val_1;
  logic [0:0]  out_idx_1;

  always #5 clk = ~clk;

  float_argmax_stream #(.E_BIT(5), .F_BIT(10), .D_LEN(16), .N_IN(4), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_idx(out_idx), .busy(busy)
  );

  float_argmax_stream #(.E_BIT(5), .F_BIT(10), .D_LEN(16), .N_IN(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .in_data(in_data_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_val(out_val_1),
    .out_idx(out_idx_1), .busy(busy_1)
  );

  typedef struct packed {
    logic [15:0] v;
    logic [1:0]  i;
  } res_t;

  typedef struct packed {
    logic [3:0][15:0] d;
    res_t             r;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  res_t sb[$];
  res_t mon_exp;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] e,
                              input logic [15:0] v_first, input logic [1:0] i_first,
                              input logic [15:0] v_last, input logic [1:0] i_last);
    vec_t t;
    t.d[0] = a; t.d[1] = b; t.d[2] = c; t.d[3] = e;
    t.r.v  = TIE_LAST ? v_last : v_first;
    t.r.i  = TIE_LAST ? i_last : i_first;
    return t;
  endfunction

  // Scoreboard consumer: compare every output transfer against the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("out_val", {16'd0, out_val}, {16'd0, mon_exp.v});
        chk("out_idx", {30'd0, out_idx}, {30'd0, mon_exp.i});
      end
    end
  end

  task automatic put(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input bit gaps);
    for (int e = 0; e < 4; e++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      if (e == 3) sb.push_back(v.r);
      put(v.d[e]);
    end
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(16'h3C00, 16'h4000, 16'hBC00, 16'h3E00, 16'h4000, 2'd1, 16'h4000, 2'd1);
    vecs[1] = mk(16'hC000, 16'hBC00, 16'hC200, 16'hC400, 16'hBC00, 2'd1, 16'hBC00, 2'd1);
    vecs[2] = mk(16'h8000, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00, 2'd2, 16'h3C00, 2'd3);
    vecs[3] = mk(16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 2'd0, 16'h8000, 2'd3);
    vecs[4] = mk(16'h7C00, 16'h7BFF, 16'hFC00, 16'h0001, 16'h7C00, 2'd0, 16'h7C00, 2'd0);
    vecs[5] = mk(16'hC400, 16'hC200, 16'hC000, 16'hBC00, 16'hBC00, 2'd3, 16'hBC00, 2'd3);
    vecs[6] = mk(16'h8000, 16'h8001, 16'h8000, 16'h8000, 16'h8000, 2'd0, 16'h8000, 2'd3);
    vecs[7] = mk(16'h0001, 16'h8001, 16'h0000, 16'h0002, 16'h0002, 2'd3, 16'h0002, 2'd3);

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;
    in_valid_1 = 1'b0; in_data_1 = 16'd0; out_ready_1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_val", {16'd0, out_val}, 32'd0);
    chk("rst_out_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid_1", {31'd0, out_valid_1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back table reductions
    for (int i = 0; i < 8; i++) send_vec(vecs[i], 1'b0);
    drain();

    // Backpressure: result held, no input consumed, IDLE the cycle after transfer
    out_ready = 1'b0;
    send_vec(vecs[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = 16'h7C00;
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_val", {16'd0, out_val}, 32'h4000);
      chk("bp_out_idx", {30'd0, out_idx}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    send_vec(vecs[1], 1'b0);
    drain();

    // clr after two elements, colliding with a third transfer
    put(16'h7C00);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    put(16'h7C00);
    in_valid = 1'b1; in_data = 16'h7C00; clr = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send_vec(vecs[5], 1'b1);
    drain();

    // Async reset in the middle of a reduction
    put(16'h3C00);
    put(16'h4000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_val", {16'd0, out_val}, 32'd0);
    chk("arst_out_idx", {30'd0, out_idx}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    send_vec(vecs[0], 1'b1);
    drain();

    // N_IN=1 instance: single element is the result
    in_valid_1 = 1'b1;
    in_data_1  = 16'hBC00;
    @(posedge clk);
    #1;
    in_valid_1 = 1'b0;
    chk("n1_out_valid", {31'd0, out_valid_1}, 32'd1);
    chk("n1_out_val", {16'd0, out_val_1}, 32'hBC00);
    chk("n1_out_idx", {31'd0, out_idx_1}, 32'd0);
    chk("n1_in_ready", {31'd0, in_ready_1}, 32'd0);
    @(posedge clk);
    #1;
    chk("n1_out_valid_clear", {31'd0, out_valid_1}, 32'd0);
    chk("n1_busy_clear", {31'd0, busy_1}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
